sha_hdr_ctrl: RTL

Sequencer that drives `sha_block` from the mining side: accepts an 80-byte Bitcoin block header and pads it into 512-bit message blocks. It issues the blocks to `sha_block` one at a time, chaining each returned intermediate hash as the next `H_prev`. It returns the final 256-bit digest with a done pulse. It sits between the nonce/header source and `sha_block`, and is the initiator side of the `en`/`M`/`H_prev` → `H`/`en_next` interface.

---
 rtl/sha_pkg.sv | 62 ++++++
 rtl/sha_msg_pad.sv | 35 +++
 rtl/sha_hdr_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// ---------------------------------------------------------------------------
// sha_pkg
// Shared constants and types for everything that drives or wraps sha_block.
// Holds the SHA-256 initial hash and round constants (one copy for all
// callers), the header/digest widths, the message-length words that go into
// the padding, and the state/block-select enums of the header sequencer.
//
// Optional feature macro: SHA_HDR_DOUBLE_SHA_EN adds the third-block states.
// ---------------------------------------------------------------------------
package sha_pkg;

    localparam int HDR_W = 640;
    localparam int DIG_W = 256;
    localparam int BLK_W = 512;

    localparam logic [63:0] HDR_LEN_BITS = 64'd640;
    localparam logic [63:0] DIG_LEN_BITS = 64'd256;

    localparam logic [255:0] SHA_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [2047:0] SHA_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISS1,
        ST_WT1,
        ST_ISS2,
        ST_WT2
`ifdef SHA_HDR_DOUBLE_SHA_EN
        ,
        ST_ISS3,
        ST_WT3
`endif
    } sha_hdr_state_t;

    typedef enum logic [1:0] {
        BLK_1,
        BLK_2,
        BLK_3
    } sha_blk_sel_t;

endpackage

// File: rtl/sha_msg_pad.sv
// ---------------------------------------------------------------------------
// sha_msg_pad
// Combinational block builder. Produces one 512-bit SHA-256 message block
// from the 80-byte header or from a returned hash, with the standard
// 1-bit/zero/length padding.
//
// Ports:
//   i_header  HDR_W  block header (big-endian)
//   i_hash    DIG_W  hash used as message for the second-pass block
//   i_sel     enum   which block to build (BLK_1 / BLK_2 / BLK_3)
//   o_block   512    resulting message block
// ---------------------------------------------------------------------------
module sha_msg_pad
    import sha_pkg::*;
(
    input  logic [HDR_W-1:0] i_header,
    input  logic [DIG_W-1:0] i_hash,
    input  sha_blk_sel_t     i_sel,
    output logic [BLK_W-1:0] o_block
);

    always_comb begin
        o_block = i_header[HDR_W-1:128];
        case (i_sel)
            BLK_1: o_block = i_header[HDR_W-1:128];
            // Header tail followed by the terminating 1, zeros and the
            // 640-bit message length.
            BLK_2: o_block = {i_header[127:0], 1'b1, 319'b0, HDR_LEN_BITS};
            // Second pass hashes the 256-bit first digest on its own.
            BLK_3: o_block = {i_hash, 1'b1, 191'b0, DIG_LEN_BITS};
            default: o_block = i_header[HDR_W-1:128];
        endcase
    end

endmodule

// File: rtl/sha_hdr_ctrl.sv
// ---------------------------------------------------------------------------
// sha_hdr_ctrl
// Sequencer that hashes an 80-byte Bitcoin header through an external
// sha_block: issues each padded block with a one-cycle sha_en pulse, waits
// for sha_en_next, chains the returned hash and finally presents the digest
// with a one-cycle done pulse.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start          begin hashing header (only honoured while idle)
//   header         HDR_W header, captured on the accepted start edge
//   busy, done     activity flag and one-cycle completion pulse
//   digest         final hash, held until the next done
//   sha_en         issue pulse to sha_block
//   sha_M          message block to sha_block
//   sha_H_prev     chaining value to sha_block
//   sha_H          hash returned by sha_block
//   sha_en_next    result-valid strobe from sha_block
//
// Optional feature macro: SHA_HDR_DOUBLE_SHA_EN hashes the first digest
// again (SHA256d) using a third block.
// ---------------------------------------------------------------------------
module sha_hdr_ctrl
    import sha_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [HDR_W-1:0] header,
    output logic             busy,
    output logic             done,
    output logic [DIG_W-1:0] digest,
    output logic             sha_en,
    output logic [BLK_W-1:0] sha_M,
    output logic [DIG_W-1:0] sha_H_prev,
    input  logic [DIG_W-1:0] sha_H,
    input  logic             sha_en_next
);

    sha_hdr_state_t   r_state;
    logic [HDR_W-1:0] r_header;
    logic             r_busy;
    logic             r_done;
    logic             r_shaEn;
    logic [BLK_W-1:0] r_shaM;
    logic [DIG_W-1:0] r_shaHPrev;
    logic [DIG_W-1:0] r_digest;

    logic [HDR_W-1:0] w_padHeader;
    sha_blk_sel_t     w_blkSel;
    logic [BLK_W-1:0] w_block;

    // Block 1 is built on the start edge itself, before the header register
    // has been loaded, so it takes the live header input.
    assign w_padHeader = (r_state == ST_IDLE) ? header : r_header;

    // The block to build is the one that will be issued on leaving the
    // current state.
    always_comb begin
        w_blkSel = BLK_1;
        case (r_state)
            ST_WT1:  w_blkSel = BLK_2;
            ST_WT2:  w_blkSel = BLK_3;
            default: w_blkSel = BLK_1;
        endcase
    end

    sha_msg_pad u_pad (
        .i_header (w_padHeader),
        .i_hash   (sha_H),
        .i_sel    (w_blkSel),
        .o_block  (w_block)
    );

    // Main sequencer. sha_en and done default low so each is a single-cycle
    // pulse; sha_M/sha_H_prev only change on entry to an issue state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_header   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_shaEn    <= 1'b0;
            r_shaM     <= '0;
            r_shaHPrev <= '0;
            r_digest   <= '0;
        end else begin
            r_shaEn <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_header   <= header;
                        r_busy     <= 1'b1;
                        r_shaEn    <= 1'b1;
                        r_shaM     <= w_block;
                        r_shaHPrev <= SHA_H0;
                        r_state    <= ST_ISS1;
                    end
                end
                ST_ISS1: r_state <= ST_WT1;
                ST_WT1: begin
                    if (sha_en_next) begin
                        r_shaEn    <= 1'b1;
                        r_shaM     <= w_block;
                        r_shaHPrev <= sha_H;
                        r_state    <= ST_ISS2;
                    end
                end
                ST_ISS2: r_state <= ST_WT2;
                ST_WT2: begin
                    if (sha_en_next) begin
`ifdef SHA_HDR_DOUBLE_SHA_EN
                        r_shaEn    <= 1'b1;
                        r_shaM     <= w_block;
                        r_shaHPrev <= SHA_H0;
                        r_state    <= ST_ISS3;
`else
                        r_digest   <= sha_H;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
`endif
                    end
                end
`ifdef SHA_HDR_DOUBLE_SHA_EN
                ST_ISS3: r_state <= ST_WT3;
                ST_WT3: begin
                    if (sha_en_next) begin
                        r_digest <= sha_H;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign digest     = r_digest;
    assign sha_en     = r_shaEn;
    assign sha_M      = r_shaM;
    assign sha_H_prev = r_shaHPrev;

endmodule
